serial_sub_ctrl: RTL and testbench
==================================

Name: serial_sub_ctrl

Overview:
Bit-serial N-bit subtractor controller that computes A − B by sequencing a single full-subtractor cell (two half-subtractor stages plus an OR) one bit per clock, LSB first. It accepts a start pulse with parallel operands and shifts them through the cell. It then reports a parallel difference, the final borrow and a one-cycle done pulse. It is the area-minimal alternative to a W-wide ripple subtractor in the arithmetic library.

Parameters:
W, 8, operand/result width in bits; legal range 2..32
CW, $clog2(W), bit-counter width (derived localparam, not overridable)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
a_in  input  W  minuend, captured on the accepting edge
b_in  input  W  subtrahend, captured on the accepting edge
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse; result valid
diff  output  W  A − B modulo 2^W, held until next accept
borrow_out  output  1  1 when A < B (unsigned), held with diff

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE; busy=0, done=0, diff=0, borrow_out=0; shift regs, borrow reg and counter all 0. Reset mid-operation aborts and discards the partial result.
- States: IDLE, SHIFT, DONE.
- IDLE: on an edge with start=1, load a_sh<=a_in, b_sh<=b_in, br<=0, cnt<=W-1, go to SHIFT. start=0 stays in IDLE.
- SHIFT, one edge per bit:
  - Compute d1=a^b, b1=~a&b (HS stage 1), d=d1^br, b2=~d1&br (HS stage 2), where a=a_sh[0] and b=b_sh[0].
  - Shift a_sh and b_sh right by 1; shift d into res_sh at MSB (res_sh <= {d, res_sh[W-1:1]}); br<=b1|b2.
  - If cnt==0, go to DONE; else cnt<=cnt-1.
- DONE: lasts one cycle. done=1; diff=res_sh and borrow_out=br become visible this cycle. Next edge returns to IDLE.
- Timing: busy=1 for exactly W cycles after the accepting edge. done is high in cycle W+1. An accept-to-accept throughput of W+2 cycles is the minimum.
- start while in SHIFT or DONE is ignored (not queued). Operands change freely after the accepting edge.
- diff/borrow_out are registered, updated only on entry to DONE, and held through IDLE. They are not cleared by a new accept until that operation's DONE.
- All arithmetic is unsigned modulo 2^W; borrow_out equals the borrow out of bit W-1.
- busy and done are never high simultaneously.

Optional Feature:
- Macro SERIAL_SUB_ZERO_FLAG_EN.
- Defined: adds output port zero (1 bit), reset 0. It is updated together with diff: zero=1 iff the result is all zeros. It is computed serially as a sticky OR of d bits during SHIFT, with no W-wide reduction.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package serial_sub_pkg: state encoding constants (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the default W.
- One sub-module, fs_cell: combinational full subtractor built from two half-subtractor stages plus an OR gate.
  - Ports: a, b, bin, d, bout.
  - Instantiated once in serial_sub_ctrl.
  - Unit-testable standalone.

Test Plan:
- W=8, a_in=200, b_in=55, one-cycle start → busy high 8 cycles, done in cycle 9, diff=145, borrow_out=0 (zero=0 if enabled).
- a_in=5, b_in=10 → diff=251 (0xFB), borrow_out=1.
- a_in=0x5A, b_in=0x5A → diff=0x00, borrow_out=0, zero=1 (macro on). Then a_in=0, b_in=1 → diff=0xFF, borrow_out=1, zero=0.
- Accept 200−55, then pulse start with a_in=1, b_in=1 at cycles 3 and in the DONE cycle → both ignored. Result stays 145; busy returns low, then a fresh start is accepted.
- Start 100−1, assert rst_n=0 asynchronously in cycle 4 → all outputs 0 immediately. After release, no done appears without a new start; a new 9−3 gives diff=6.
- Exhaustive W=4 sweep of all 256 (a,b) pairs back-to-back → diff==(a−b)&0xF and borrow_out==(a<b) for each, each done exactly one cycle.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared state encoding and default width for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// Request/result bundle for serial_sub_ctrl; SERIAL_SUB_ZERO_FLAG_EN adds the zero flag.
interface serial_sub_ctrl_if
  import serial_sub_pkg::*;
#(
  parameter int W = W_DEFAULT
);

  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
  logic         zero;

  modport master (output start, a_in, b_in,
                  input  busy, done, diff, borrow_out, zero);
  modport slave  (input  start, a_in, b_in,
                  output busy, done, diff, borrow_out, zero);
`else
  modport master (output start, a_in, b_in,
                  input  busy, done, diff, borrow_out);
  modport slave  (input  start, a_in, b_in,
                  output busy, done, diff, borrow_out);
`endif

endinterface

// File: rtl/serial_sub_ctrl_fs_cell.sv
// Combinational full subtractor: two half-subtractor stages whose borrows are ORed.
module fs_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic d1;
  logic b1;
  logic b2;

  assign d1   = a ^ b;
  assign b1   = ~a & b;
  assign d    = d1 ^ bin;
  assign b2   = ~d1 & bin;
  assign bout = b1 | b2;

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial A-B controller: one fs_cell evaluated per clock, LSB first.
// Optional zero flag enabled by defining SERIAL_SUB_ZERO_FLAG_EN.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  serial_sub_ctrl_if.slave bus
);

  localparam int CW = $clog2(W);

  state_t          state_reg;
  state_t          state_next;
  logic [W-1:0]    a_sh_reg;
  logic [W-1:0]    b_sh_reg;
  logic [W-1:0]    res_sh_reg;
  logic [W-1:0]    diff_reg;
  logic            br_reg;
  logic            borrow_reg;
  logic [CW-1:0]   cnt_reg;
  logic            d_bit;
  logic            bout_bit;
  logic            last_bit;

  fs_cell u_fs_cell (
    .a    (a_sh_reg[0]),
    .b    (b_sh_reg[0]),
    .bin  (br_reg),
    .d    (d_bit),
    .bout (bout_bit)
  );

  assign last_bit = (cnt_reg == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = SHIFT;
      SHIFT:   if (last_bit)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      res_sh_reg <= '0;
      br_reg     <= 1'b0;
      cnt_reg    <= '0;
      diff_reg   <= '0;
      borrow_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            a_sh_reg <= bus.a_in;
            b_sh_reg <= bus.b_in;
            br_reg   <= 1'b0;
            cnt_reg  <= CW'(W - 1);
          end
        end
        SHIFT: begin
          a_sh_reg   <= a_sh_reg >> 1;
          b_sh_reg   <= b_sh_reg >> 1;
          res_sh_reg <= {d_bit, res_sh_reg[W-1:1]};
          br_reg     <= bout_bit;
          // Results publish on the DONE-entry edge and are held until the next DONE.
          if (last_bit) begin
            diff_reg   <= {d_bit, res_sh_reg[W-1:1]};
            borrow_reg <= bout_bit;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = (state_reg == SHIFT);
  assign bus.done       = (state_reg == DONE);
  assign bus.diff       = diff_reg;
  assign bus.borrow_out = borrow_reg;

`ifdef SERIAL_SUB_ZERO_FLAG_EN
  logic nz_reg;
  logic zero_reg;

  // Sticky OR of difference bits, so no W-wide reduction is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nz_reg   <= 1'b0;
      zero_reg <= 1'b0;
    end else begin
      if (state_reg == IDLE && bus.start) begin
        nz_reg <= 1'b0;
      end else if (state_reg == SHIFT) begin
        nz_reg <= nz_reg | d_bit;
        if (last_bit) begin
          zero_reg <= ~(nz_reg | d_bit);
        end
      end
    end
  end

  assign bus.zero = zero_reg;
`endif

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl (W=8 directed/random, W=4 exhaustive sweep).
module tb_serial_sub_ctrl;
  import serial_sub_pkg::*;

  localparam int W8 = 8;
  localparam int W4 = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_sub_ctrl_if #(.W(W8)) bus8 ();
  serial_sub_ctrl_if #(.W(W4)) bus4 ();

  serial_sub_ctrl #(.W(W8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_sub_ctrl #(.W(W4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  int checks = 0;
  int passed = 0;

  logic [7:0] held_diff   = 8'd0;
  logic       held_borrow = 1'b0;
  logic       held_zero   = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full W=8 operation starting from IDLE; ends one cycle after DONE.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input string tag);
    logic [7:0] ed;
    logic       eb;
    logic       ez;
    ed = a - b;
    eb = (a < b);
    ez = (ed == 8'd0);
    bus8.start = 1'b1;
    bus8.a_in  = a;
    bus8.b_in  = b;
    tick();
    bus8.start = 1'b0;
    bus8.a_in  = 8'($urandom);
    bus8.b_in  = 8'($urandom);
    for (int c = 1; c <= W8; c++) begin
      checks++;
      if (bus8.busy === 1'b1 && bus8.done === 1'b0) passed++;
      else $display("FAIL %s busy_cycle%0d: busy=%b done=%b, want busy=1 done=0", tag, c, bus8.busy, bus8.done);
      if (c == 1) begin
        checks++;
        if (bus8.diff === held_diff && bus8.borrow_out === held_borrow) passed++;
        else $display("FAIL %s held_result: diff=%0d borrow=%b, want diff=%0d borrow=%b", tag, bus8.diff, bus8.borrow_out, held_diff, held_borrow);
      end
      tick();
    end
    checks++;
    if (bus8.done === 1'b1 && bus8.busy === 1'b0) passed++;
    else $display("FAIL %s done_cycle: done=%b busy=%b, want done=1 busy=0", tag, bus8.done, bus8.busy);
    checks++;
    if (bus8.diff === ed) passed++;
    else $display("FAIL %s diff: got %0d, want %0d", tag, bus8.diff, ed);
    checks++;
    if (bus8.borrow_out === eb) passed++;
    else $display("FAIL %s borrow_out: got %b, want %b", tag, bus8.borrow_out, eb);
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    checks++;
    if (bus8.zero === ez) passed++;
    else $display("FAIL %s zero: got %b, want %b", tag, bus8.zero, ez);
`endif
    $display("%s: %0d - %0d -> diff=%0d borrow=%b", tag, a, b, bus8.diff, bus8.borrow_out);
    held_diff   = ed;
    held_borrow = eb;
    held_zero   = ez;
    tick();
    checks++;
    if (bus8.done === 1'b0 && bus8.busy === 1'b0 && bus8.diff === ed) passed++;
    else $display("FAIL %s after_done: done=%b busy=%b diff=%0d, want 0 0 %0d", tag, bus8.done, bus8.busy, bus8.diff, ed);
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (bus8.busy === 1'b0 && bus8.done === 1'b0 && bus8.diff === 8'd0 && bus8.borrow_out === 1'b0) passed++;
    else $display("FAIL reset_w8: busy=%b done=%b diff=%0d borrow=%b, want all 0", bus8.busy, bus8.done, bus8.diff, bus8.borrow_out);
    checks++;
    if (bus4.busy === 1'b0 && bus4.done === 1'b0 && bus4.diff === 4'd0 && bus4.borrow_out === 1'b0) passed++;
    else $display("FAIL reset_w4: busy=%b done=%b diff=%0d borrow=%b, want all 0", bus4.busy, bus4.done, bus4.diff, bus4.borrow_out);
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    checks++;
    if (bus8.zero === 1'b0) passed++;
    else $display("FAIL reset_zero: got %b, want 0", bus8.zero);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if (bus8.busy === 1'b0 && bus8.done === 1'b0) passed++;
    else $display("FAIL idle_no_start: busy=%b done=%b, want 0 0", bus8.busy, bus8.done);
  endtask

  task automatic test_directed();
    run_op(8'd200, 8'd55, "dir_200_55");
    run_op(8'd5, 8'd10, "dir_5_10");
    run_op(8'h5A, 8'h5A, "dir_5A_5A");
    run_op(8'd0, 8'd1, "dir_0_1");
    run_op(8'hFF, 8'h00, "dir_FF_0");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      run_op(8'($urandom), 8'($urandom), "rand");
    end
  endtask

  task automatic test_ignore_start();
    bus8.start = 1'b1;
    bus8.a_in  = 8'd200;
    bus8.b_in  = 8'd55;
    tick();
    bus8.start = 1'b0;
    for (int c = 1; c <= W8; c++) begin
      bus8.start = (c == 3);
      bus8.a_in  = 8'd1;
      bus8.b_in  = 8'd1;
      tick();
    end
    bus8.start = 1'b0;
    checks++;
    if (bus8.done === 1'b1 && bus8.diff === 8'd145 && bus8.borrow_out === 1'b0) passed++;
    else $display("FAIL ignore_done: done=%b diff=%0d borrow=%b, want 1 145 0", bus8.done, bus8.diff, bus8.borrow_out);
    $display("ignore: 200 - 55 -> diff=%0d borrow=%b", bus8.diff, bus8.borrow_out);
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    checks++;
    if (bus8.busy === 1'b0 && bus8.done === 1'b0 && bus8.diff === 8'd145) passed++;
    else $display("FAIL ignore_in_done: busy=%b done=%b diff=%0d, want 0 0 145", bus8.busy, bus8.done, bus8.diff);
    tick();
    checks++;
    if (bus8.busy === 1'b0 && bus8.diff === 8'd145) passed++;
    else $display("FAIL ignore_idle: busy=%b diff=%0d, want 0 145", bus8.busy, bus8.diff);
    held_diff   = 8'd145;
    held_borrow = 1'b0;
    held_zero   = 1'b0;
    run_op(8'd1, 8'd1, "fresh_1_1");
  endtask

  task automatic test_reset_mid();
    bus8.start = 1'b1;
    bus8.a_in  = 8'd100;
    bus8.b_in  = 8'd1;
    tick();
    bus8.start = 1'b0;
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus8.busy === 1'b0 && bus8.done === 1'b0 && bus8.diff === 8'd0 && bus8.borrow_out === 1'b0) passed++;
    else $display("FAIL async_reset: busy=%b done=%b diff=%0d borrow=%b, want all 0", bus8.busy, bus8.done, bus8.diff, bus8.borrow_out);
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    checks++;
    if (bus8.zero === 1'b0) passed++;
    else $display("FAIL async_reset_zero: got %b, want 0", bus8.zero);
`endif
    held_diff   = 8'd0;
    held_borrow = 1'b0;
    held_zero   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < W8 + 4; c++) begin
      tick();
      checks++;
      if (bus8.done === 1'b0 && bus8.busy === 1'b0) passed++;
      else $display("FAIL post_reset_idle%0d: done=%b busy=%b, want 0 0", c, bus8.done, bus8.busy);
    end
    $display("reset_mid: 100 - 1 aborted");
    run_op(8'd9, 8'd3, "after_reset_9_3");
  endtask

  task automatic test_back_to_back_w4();
    int shown_fail;
    shown_fail = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        logic [3:0] ed;
        logic       eb;
        logic       timing_ok;
        ed = 4'(a - b);
        eb = (a < b);
        timing_ok = 1'b1;
        bus4.start = 1'b1;
        bus4.a_in  = 4'(a);
        bus4.b_in  = 4'(b);
        tick();
        bus4.start = 1'b0;
        bus4.a_in  = 4'($urandom);
        bus4.b_in  = 4'($urandom);
        for (int c = 1; c <= W4; c++) begin
          if (!(bus4.busy === 1'b1 && bus4.done === 1'b0)) timing_ok = 1'b0;
          tick();
        end
        if (!(bus4.done === 1'b1 && bus4.busy === 1'b0)) timing_ok = 1'b0;
        checks++;
        if (bus4.diff === ed && bus4.borrow_out === eb) passed++;
        else if (shown_fail++ < 20) $display("FAIL w4_result %0d-%0d: diff=%0d borrow=%b, want %0d %b", a, b, bus4.diff, bus4.borrow_out, ed, eb);
        $display("w4: %0d - %0d -> diff=%0d borrow=%b", a, b, bus4.diff, bus4.borrow_out);
        tick();
        if (bus4.done !== 1'b0) timing_ok = 1'b0;
        checks++;
        if (timing_ok) passed++;
        else if (shown_fail++ < 20) $display("FAIL w4_timing %0d-%0d: busy/done sequence wrong, want busy W cycles then done 1 cycle", a, b);
      end
    end
  endtask

  initial begin
    bus8.start = 1'b0;
    bus8.a_in  = 8'd0;
    bus8.b_in  = 8'd0;
    bus4.start = 1'b0;
    bus4.a_in  = 4'd0;
    bus4.b_in  = 4'd0;
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back_w4();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
